bcd_scan_counter: RTL and testbench

//   Multi-digit decimal up/down counter with a built-in tick prescaler and a

---
 rtl/bcd_scan_counter.sv | 142 ++++++++++++++
 tb/tb_bcd_scan_counter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - multi-digit BCD up/down counter with tick prescaler and display scan mux
module bcd_scan_counter #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 1000,
    parameter int SCAN_DIV = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena_i,
    input  logic                  up_i,
    input  logic                  clear_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic [3:0]            digit_o,
    output logic [DIGITS-1:0]     digit_sel_o,
    output logic                  wrap_o
);

    localparam int P_W = $clog2(TICK_DIV);
    localparam int S_W = $clog2(SCAN_DIV);
    localparam int I_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [P_W-1:0] P_LAST = P_W'(TICK_DIV - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(SCAN_DIV - 1);
    localparam logic [I_W-1:0] I_LAST = I_W'(DIGITS - 1);

    logic [P_W-1:0]        r_presc;
    logic [S_W-1:0]        r_scan;
    logic [I_W-1:0]        r_idx;
    logic [4*DIGITS-1:0]   r_count;
    logic [3:0]            r_digit;
    logic [DIGITS-1:0]     r_sel;
    logic                  r_wrap;

    logic                  w_tick;
    logic                  w_scan_last;
    logic [4*DIGITS-1:0]   w_next;
    logic                  w_full_ripple;
    logic [3:0]            w_digit;
    logic [DIGITS-1:0]     w_sel;

    assign w_tick      = ena_i && (r_presc == P_LAST);
    assign w_scan_last = (r_scan == S_LAST);

    // Ripple-carry / ripple-borrow BCD step; a carry out of the top digit means wrap-around
    always_comb begin : step_logic
        logic [3:0] v_dig;
        logic       v_ripple;
        w_next   = r_count;
        v_ripple = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            v_dig = r_count[4*i +: 4];
            if (v_ripple) begin
                if (up_i) begin
                    if (v_dig >= 4'd9) begin
                        w_next[4*i +: 4] = 4'd0;
                    end else begin
                        w_next[4*i +: 4] = v_dig + 4'd1;
                        v_ripple         = 1'b0;
                    end
                end else begin
                    if (v_dig == 4'd0) begin
                        w_next[4*i +: 4] = 4'd9;
                    end else begin
                        // out-of-range digits are folded back into 0..9
                        w_next[4*i +: 4] = (v_dig > 4'd9) ? 4'd8 : (v_dig - 4'd1);
                        v_ripple         = 1'b0;
                    end
                end
            end
        end
        w_full_ripple = v_ripple;
    end

    // Select the scanned digit and build its one-hot enable
    always_comb begin
        w_digit = 4'd0;
        w_sel   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == I_W'(i)) begin
                w_digit  = r_count[4*i +: 4];
                w_sel[i] = 1'b1;
            end
        end
    end

    // Prescaler: runs only while enabled, restarts on tick or clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (clear_i || w_tick) begin
            r_presc <= '0;
        end else if (ena_i) begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Count register and wrap pulse; clear overrides a same-cycle tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (clear_i) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (w_tick) begin
            r_count <= w_next;
            r_wrap  <= w_full_ripple;
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    // Free-running scan divider and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else begin
            r_scan <= w_scan_last ? '0 : (r_scan + 1'b1);
            if (w_scan_last) begin
                r_idx <= (r_idx == I_LAST) ? '0 : (r_idx + 1'b1);
            end
        end
    end

    // Digit and enable registered together so the decoder never sees them disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
            r_sel   <= DIGITS'(1);
        end else begin
            r_digit <= w_digit;
            r_sel   <= w_sel;
        end
    end

    assign count_o     = r_count;
    assign digit_o     = r_digit;
    assign digit_sel_o = r_sel;
    assign wrap_o      = r_wrap;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - directed self-checking bench for bcd_scan_counter
module tb_bcd_scan_counter;

    logic       clk;
    logic       rst_n;
    logic       ena_i;
    logic       up_i;
    logic       clear_i;
    logic [7:0] count_o;
    logic [3:0] digit_o;
    logic [1:0] digit_sel_o;
    logic       wrap_o;

    int checks;
    int errors;

    bcd_scan_counter #(
        .DIGITS   (2),
        .TICK_DIV (4),
        .SCAN_DIV (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena_i       (ena_i),
        .up_i        (up_i),
        .clear_i     (clear_i),
        .count_o     (count_o),
        .digit_o     (digit_o),
        .digit_sel_o (digit_sel_o),
        .wrap_o      (wrap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // advance n rising edges and settle 1 time unit after the last one
    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(count_o), 32'h00);
        check({tag, "_digit"}, 32'(digit_o), 32'h0);
        check({tag, "_sel"},   32'(digit_sel_o), 32'h1);
        check({tag, "_wrap"},  32'(wrap_o), 32'h0);
    endtask

    initial begin
        logic [7:0] exp_bcd;
        logic [1:0] prev_sel;
        logic [1:0] s;
        bit         seen;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        ena_i   = 1'b1;
        up_i    = 1'b1;
        clear_i = 1'b0;

        // 1: reset state, then count up every 4 clocks to 0x10
        clks(2);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            clks(4);
            exp_bcd = 8'((i / 10) * 16 + (i % 10));
            check("up_count", 32'(count_o), 32'(exp_bcd));
            check("up_nowrap", 32'(wrap_o), 32'h0);
        end

        // 2: count up to 0x99, wrap to 0x00, then wrap down to 0x99
        clks(89 * 4);
        check("preload_99", 32'(count_o), 32'h99);
        clks(3);
        check("pre_wrap_hold", 32'(count_o), 32'h99);
        check("pre_wrap_lo", 32'(wrap_o), 32'h0);
        clks(1);
        check("wrap_up_count", 32'(count_o), 32'h00);
        check("wrap_up_pulse", 32'(wrap_o), 32'h1);
        clks(1);
        check("wrap_up_end", 32'(wrap_o), 32'h0);
        up_i = 1'b0;
        clks(3);
        check("wrap_dn_count", 32'(count_o), 32'h99);
        check("wrap_dn_pulse", 32'(wrap_o), 32'h1);
        clks(1);
        check("wrap_dn_end", 32'(wrap_o), 32'h0);

        // 3: prescaler sits at 1 here; hold for 10 clocks, then 3 more to tick
        ena_i = 1'b0;
        clks(10);
        check("hold_count", 32'(count_o), 32'h99);
        ena_i = 1'b1;
        clks(2);
        check("resume_early", 32'(count_o), 32'h99);
        clks(1);
        check("resume_step", 32'(count_o), 32'h98);

        // 4: clear on the same cycle as a tick at 0x99
        up_i = 1'b1;
        clks(4);
        check("back_to_99", 32'(count_o), 32'h99);
        clks(3);
        clear_i = 1'b1;
        clks(1);
        clear_i = 1'b0;
        check("clear_count", 32'(count_o), 32'h00);
        check("clear_nowrap", 32'(wrap_o), 32'h0);
        clks(3);
        check("clear_presc_early", 32'(count_o), 32'h00);
        check("clear_nowrap2", 32'(wrap_o), 32'h0);
        clks(1);
        check("clear_presc_step", 32'(count_o), 32'h01);

        // 5: hold 0x47 and watch the scan
        clks(46 * 4);
        ena_i = 1'b0;
        check("hold_47", 32'(count_o), 32'h47);
        prev_sel = digit_sel_o;
        seen     = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            clks(1);
            if (digit_sel_o != prev_sel) seen = 1'b1;
        end
        check("scan_edge_found", 32'(seen), 32'h1);
        for (int k = 0; k < 4; k++) begin
            s = digit_sel_o;
            check("scan_digit", 32'(digit_o), (s == 2'b01) ? 32'h7 : 32'h4);
            for (int j = 0; j < 2; j++) begin
                clks(1);
                check("scan_hold", 32'(digit_sel_o), 32'(s));
                check("scan_digit", 32'(digit_o), (s == 2'b01) ? 32'h7 : 32'h4);
            end
            clks(1);
            check("scan_toggle", 32'(digit_sel_o), (s == 2'b01) ? 32'h2 : 32'h1);
        end

        // 6: count down to 0x36, then asynchronous reset mid-scan
        ena_i = 1'b1;
        up_i  = 1'b0;
        clks(11 * 4);
        ena_i = 1'b0;
        check("reach_36", 32'(count_o), 32'h36);
        clks(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        ena_i = 1'b1;
        up_i  = 1'b1;
        clks(1);
        check("resume_sel", 32'(digit_sel_o), 32'h1);
        check("resume_digit", 32'(digit_o), 32'h0);
        clks(3);
        check("resume_count", 32'(count_o), 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
